spi_master_arb: RTL and testbench

// - Two-requester SPI master front end for the 8-bit negedge-sampling SPI slave.
// - Arbitrates between requesters and latches the granted byte.
// - Generates the SPI pins sclk, cs and mosi from the system clock.
// - Sequences the 10-period frame the slave needs: setup, 8 data bits MSB first, completion.

---
 rtl/spi_master_arb.sv | 170 +++++++++++++++++
 tb/tb_spi_master_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Two-requester SPI master: arbitrates, latches the granted byte and plays a 10-period frame
// (setup, 8 data bits MSB first, completion). Define SPI_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module spi_master_arb #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] din0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] din1,
    output logic       gnt1,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic       owner
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_PER = 4'd9;

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic       half_q, half_d;
    logic [3:0] per_q, per_d;
    logic [7:0] shreg_q, shreg_d;
    logic       sclk_q, sclk_d;
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic       done_q, done_d;
    logic       owner_q, owner_d;
    logic       any_req, win, grant, div_end;

    assign any_req = req0 | req1;
    // Grant is decided in the IDLE cycle itself so back-to-back frames are 22*CLK_DIV+1 clk apart.
    assign grant   = (state_q == IDLE) && any_req && !rst;
    assign div_end = (div_q == DIV_LAST);

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign win = !req0;
`else
    logic prio_q, prio_d;
    assign win = (req0 && req1) ? prio_q : req1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= 1'b0;
            per_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            per_q   <= per_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            owner_q <= owner_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
            prio_q  <= prio_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SHIFT;
            SHIFT:   if (div_end && half_q && per_q == LAST_PER) state_d = GAP;
            GAP:     if (div_end && half_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        half_d  = half_q;
        per_d   = per_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        owner_d = owner_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    shreg_d = win ? din1 : din0;
                    owner_d = win;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    prio_d  = !win;
`endif
                    cs_d    = 1'b0;
                    div_d   = '0;
                    half_d  = 1'b0;
                    per_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!half_q) begin
                        // Rising edge: mosi changes here so it is stable across the slave's falling-edge sample.
                        half_d = 1'b1;
                        sclk_d = 1'b1;
                        if (per_q >= 4'd1 && per_q <= 4'd8) begin
                            mosi_d  = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else begin
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                        if (per_q == LAST_PER) begin
                            cs_d   = 1'b1;
                            mosi_d = 1'b0;
                            done_d = 1'b1;
                            per_d  = '0;
                        end else begin
                            per_d = per_q + 4'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d  = '0;
                    half_d = !half_q;
                end
            end
            default: ;
        endcase
    end

    assign gnt0  = grant && !win;
    assign gnt1  = grant && win;
    assign busy  = (state_q != IDLE) || grant;
    assign owner = grant ? win : owner_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;
    assign done  = done_q;
endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: one instance at CLK_DIV=4 with a receiving-slave monitor,
// one at CLK_DIV=1 with a permanently held request for frame timing.
module tb_spi_master_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic       gnt0, gnt1, sclk, cs, mosi, busy, done, owner;

    logic       req0_f = 1'b1, req1_f = 1'b0;
    logic [7:0] din0_f = 8'h5A, din1_f = 8'h00;
    logic       gnt0_f, gnt1_f, sclk_f, cs_f, mosi_f, busy_f, done_f, owner_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_master_arb #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .gnt0(gnt0),
        .req1(req1), .din1(din1), .gnt1(gnt1),
        .sclk(sclk), .cs(cs), .mosi(mosi),
        .busy(busy), .done(done), .owner(owner)
    );

    spi_master_arb #(.CLK_DIV(1)) dut_f (
        .clk(clk), .rst(rst),
        .req0(req0_f), .din0(din0_f), .gnt0(gnt0_f),
        .req1(req1_f), .din1(din1_f), .gnt1(gnt1_f),
        .sclk(sclk_f), .cs(cs_f), .mosi(mosi_f),
        .busy(busy_f), .done(done_f), .owner(owner_f)
    );

    // Receiving-slave monitor for the CLK_DIV=4 instance: samples mosi at sclk falls.
    int         cyc = 0;
    logic       prev_sclk = 1'b0, prev_mosi = 1'b0;
    int         nfalls = 0, rx_falls = 0;
    logic [7:0] rx = 8'h00, rx_byte = 8'h00;
    int         cs_cnt = 0, cs_low_len = 0;
    int         done_cnt = 0;
    logic       done_owner = 1'b0;
    int         last_gnt = 0, last_spacing = 0;
    logic       gnt_log[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (gnt0 || gnt1) begin
            gnt_log.push_back(gnt1);
            last_spacing <= cyc - last_gnt;
            last_gnt     <= cyc;
            nfalls       <= 0;
        end else if (prev_sclk && !sclk) begin
            if (nfalls >= 1 && nfalls <= 8) rx <= {rx[6:0], prev_mosi};
            nfalls <= nfalls + 1;
        end
        if (!cs) cs_cnt <= cs_cnt + 1;
        else begin
            if (cs_cnt != 0) cs_low_len <= cs_cnt;
            cs_cnt <= 0;
        end
        if (done) begin
            done_cnt   <= done_cnt + 1;
            done_owner <= owner;
            rx_byte    <= rx;
            rx_falls   <= (prev_sclk && !sclk) ? nfalls + 1 : nfalls;
        end
        prev_sclk <= sclk;
        prev_mosi <= mosi;
    end

    // Timing monitor for the CLK_DIV=1 instance.
    logic prev_sclk_f = 1'b0;
    int   cs_cnt_f = 0, cs_low_len_f = 0;
    int   last_gnt_f = 0, spacing_f = 0, last_done_f = 0, done_to_gnt_f = 0;
    int   last_rise_f = 0, sclk_per_f = 0;

    always @(negedge clk) begin
        if (gnt0_f || gnt1_f) begin
            spacing_f     <= cyc - last_gnt_f;
            last_gnt_f    <= cyc;
            done_to_gnt_f <= cyc - last_done_f;
        end
        if (done_f) last_done_f <= cyc;
        if (!prev_sclk_f && sclk_f) begin
            sclk_per_f  <= cyc - last_rise_f;
            last_rise_f <= cyc;
        end
        if (!cs_f) cs_cnt_f <= cs_cnt_f + 1;
        else begin
            if (cs_cnt_f != 0) cs_low_len_f <= cs_cnt_f;
            cs_cnt_f <= 0;
        end
        prev_sclk_f <= sclk_f;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int limit);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < limit) begin
            tick(1);
            k++;
        end
        if (done_cnt == start) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] rr_byte;
    logic       rr_own;
    int         base;
    int         d0;

    initial begin
        tick(3);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_owner", owner, 0);
        rst = 1'b0;
        tick(2);

        // Single frame from requester 0, byte A5; din/req changed right after grant.
        din0 = 8'hA5; req0 = 1'b1; #1;
        check("a5_gnt0", gnt0, 1);
        check("a5_gnt1", gnt1, 0);
        check("a5_busy", busy, 1);
        tick(1);
        req0 = 1'b0; din0 = 8'h00;
        check("a5_cs_low_1clk", cs, 0);
        check("a5_gnt0_pulse", gnt0, 0);
        wait_done(400);
        check("a5_cs_low_len", cs_low_len, 80);
        check("a5_slave_byte", rx_byte, 8'hA5);
        check("a5_slave_falls", rx_falls, 10);
        check("a5_done_owner", done_owner, 0);
        check("a5_busy_gap", busy, 1);
        check("a5_cs_gap", cs, 1);
        tick(7);
        check("a5_busy_idle", busy, 0);

        // Reset in the high half of p=4 aborts the frame with no done pulse.
        din0 = 8'hFF; req0 = 1'b1; #1;
        check("ab_gnt0", gnt0, 1);
        tick(1);
        req0 = 1'b0;
        tick(36);
        check("ab_pre_sclk", sclk, 1);
        check("ab_pre_mosi", mosi, 1);
        d0 = done_cnt;
        rst = 1'b1; #1;
        check("ab_cs", cs, 1);
        check("ab_sclk", sclk, 0);
        check("ab_mosi", mosi, 0);
        check("ab_busy_done", {busy, done}, 0);
        check("ab_gnt", {gnt0, gnt1}, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("ab_no_done", done_cnt, d0);

        // Lone requester 1 after the abort.
        din1 = 8'h81; req1 = 1'b1; #1;
        check("r1_gnt1", gnt1, 1);
        check("r1_owner", owner, 1);
        tick(1);
        req1 = 1'b0;
        wait_done(400);
        check("r1_slave_byte", rx_byte, 8'h81);
        check("r1_done_owner", done_owner, 1);
        check("r1_slave_falls", rx_falls, 10);
        tick(8);

        // Both requesters held: round-robin alternates, fixed priority always serves 0.
        base = gnt_log.size();
        din0 = 8'h3C; din1 = 8'hC3; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(400);
`ifdef SPI_ARB_FIXED_PRIO_EN
            rr_own = 1'b0;
`else
            rr_own = i[0];
`endif
            rr_byte = rr_own ? 8'hC3 : 8'h3C;
            check($sformatf("both_grant%0d", i), gnt_log[base + i], rr_own);
            check($sformatf("both_owner%0d", i), done_owner, rr_own);
            check($sformatf("both_byte%0d", i), rx_byte, rr_byte);
            if (i > 0) check($sformatf("both_spacing%0d", i), last_spacing, 89);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(20);

        check("div1_cs_low_len", cs_low_len_f, 20);
        check("div1_sclk_period", sclk_per_f, 2);
        check("div1_done_to_gnt", done_to_gnt_f, 2);
        check("div1_gnt_spacing", spacing_f, 23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
